// File: rtl/sbus_axi_arbiter_if.sv
// AXI4 bundle shared by the arbiter's slave ports and its master port.
// The master port instance is built with ID_W one bit wider than the slave ports.
interface sbus_axi_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ID_W   = 12
);
  localparam int unsigned STRB_W = DATA_W / 8;

  logic              awvalid, awready;
  logic [ADDR_W-1:0] awaddr;
  logic [ID_W-1:0]   awid;
  logic [7:0]        awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;

  logic              wvalid, wready, wlast;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;

  logic              bvalid, bready;
  logic [ID_W-1:0]   bid;
  logic [1:0]        bresp;

  logic              arvalid, arready;
  logic [ADDR_W-1:0] araddr;
  logic [ID_W-1:0]   arid;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;

  logic              rvalid, rready, rlast;
  logic [DATA_W-1:0] rdata;
  logic [ID_W-1:0]   rid;
  logic [1:0]        rresp;

  modport master (
    output awvalid, awaddr, awid, awlen, awsize, awburst, input awready,
    output wvalid, wdata, wstrb, wlast, input wready,
    input  bvalid, bid, bresp, output bready,
    output arvalid, araddr, arid, arlen, arsize, arburst, input arready,
    input  rvalid, rdata, rid, rresp, rlast, output rready
  );

  modport slave (
    input  awvalid, awaddr, awid, awlen, awsize, awburst, output awready,
    input  wvalid, wdata, wstrb, wlast, output wready,
    output bvalid, bid, bresp, input bready,
    input  arvalid, araddr, arid, arlen, arsize, arburst, output arready,
    output rvalid, rdata, rid, rresp, rlast, input rready
  );
endinterface

// File: rtl/sbus_axi_arbiter.sv
// 2:1 AXI4 arbiter: round-robin AR/AW grants, ID extended by the source port,
// W steered by a FIFO of AW winners, R/B routed back by the ID MSB.
module sbus_axi_arbiter #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned ID_W     = 12,
  parameter int unsigned WQ_DEPTH = 4
) (
  input  logic               uncoreclk,
  input  logic               uncore_rst,
  sbus_axi_arbiter_if.slave  s0_axi,
  sbus_axi_arbiter_if.slave  s1_axi,
  sbus_axi_arbiter_if.master m_axi
);
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned PTR_W  = $clog2(WQ_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;

  typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_e;

  arb_state_e ar_state_q, ar_state_d, aw_state_q, aw_state_d;
  logic       ar_port_q, ar_port_d, ar_last_q, ar_last_d;
  logic       aw_port_q, aw_port_d, aw_last_q, aw_last_d;

  logic [WQ_DEPTH-1:0] wq_mem_q, wq_mem_d;
  logic [PTR_W-1:0]    wq_wr_q, wq_wr_d, wq_rd_q, wq_rd_d;
  logic [CNT_W-1:0]    wq_cnt_q, wq_cnt_d;

  logic ar_grant, ar_hs, aw_grant, aw_valid, aw_hs;
  logic wq_full, wq_empty, wq_head, wq_push, wq_pop, w_valid, w_last;

  // Both requesting: take the port after the last winner; otherwise the lone requester.
  function automatic logic rr_pick(input logic req0, input logic req1, input logic last);
    return (req0 && req1) ? ~last : req1;
  endfunction

  assign ar_grant = (ar_state_q == ARB_GRANT);
  assign ar_hs    = ar_grant & m_axi.arready;
  assign aw_grant = (aw_state_q == ARB_GRANT);

  assign wq_full  = (wq_cnt_q == CNT_W'(WQ_DEPTH));
  assign wq_empty = (wq_cnt_q == '0);
  assign wq_head  = wq_mem_q[wq_rd_q];
  assign w_valid  = ~wq_empty & (wq_head ? s1_axi.wvalid : s0_axi.wvalid);
  assign w_last   = wq_head ? s1_axi.wlast : s0_axi.wlast;
  assign wq_pop   = w_valid & m_axi.wready & w_last;
  // A full FIFO may still take the AW when a WLAST pop frees a slot this cycle.
  assign aw_valid = aw_grant & (~wq_full | wq_pop);
  assign aw_hs    = aw_valid & m_axi.awready;
  assign wq_push  = aw_hs;

  always_comb begin
    ar_state_d = ar_state_q;
    ar_port_d  = ar_port_q;
    ar_last_d  = ar_last_q;
    aw_state_d = aw_state_q;
    aw_port_d  = aw_port_q;
    aw_last_d  = aw_last_q;
    wq_mem_d   = wq_mem_q;
    wq_wr_d    = wq_wr_q;
    wq_rd_d    = wq_rd_q;
    wq_cnt_d   = wq_cnt_q;

    if (ar_state_q == ARB_IDLE) begin
      if (s0_axi.arvalid || s1_axi.arvalid) begin
        ar_state_d = ARB_GRANT;
        ar_port_d  = rr_pick(s0_axi.arvalid, s1_axi.arvalid, ar_last_q);
      end
    end else if (ar_hs) begin
      ar_state_d = ARB_IDLE;
      ar_last_d  = ar_port_q;
    end

    if (aw_state_q == ARB_IDLE) begin
      if (s0_axi.awvalid || s1_axi.awvalid) begin
        aw_state_d = ARB_GRANT;
        aw_port_d  = rr_pick(s0_axi.awvalid, s1_axi.awvalid, aw_last_q);
      end
    end else if (aw_hs) begin
      aw_state_d = ARB_IDLE;
      aw_last_d  = aw_port_q;
    end

    if (wq_push) begin
      wq_mem_d[wq_wr_q] = aw_port_q;
      wq_wr_d           = wq_wr_q + PTR_W'(1);
    end
    if (wq_pop) wq_rd_d = wq_rd_q + PTR_W'(1);
    case ({wq_push, wq_pop})
      2'b10:   wq_cnt_d = wq_cnt_q + CNT_W'(1);
      2'b01:   wq_cnt_d = wq_cnt_q - CNT_W'(1);
      default: wq_cnt_d = wq_cnt_q;
    endcase
  end

  // Last-winner registers reset to port 1 so port 0 is favoured first.
  always_ff @(posedge uncoreclk) begin
    if (uncore_rst) begin
      ar_state_q <= ARB_IDLE;
      ar_port_q  <= 1'b0;
      ar_last_q  <= 1'b1;
      aw_state_q <= ARB_IDLE;
      aw_port_q  <= 1'b0;
      aw_last_q  <= 1'b1;
      wq_mem_q   <= '0;
      wq_wr_q    <= '0;
      wq_rd_q    <= '0;
      wq_cnt_q   <= '0;
    end else begin
      ar_state_q <= ar_state_d;
      ar_port_q  <= ar_port_d;
      ar_last_q  <= ar_last_d;
      aw_state_q <= aw_state_d;
      aw_port_q  <= aw_port_d;
      aw_last_q  <= aw_last_d;
      wq_mem_q   <= wq_mem_d;
      wq_wr_q    <= wq_wr_d;
      wq_rd_q    <= wq_rd_d;
      wq_cnt_q   <= wq_cnt_d;
    end
  end

  assign m_axi.arvalid  = ar_grant;
  assign m_axi.araddr   = ADDR_W'(ar_port_q ? s1_axi.araddr : s0_axi.araddr);
  assign m_axi.arid     = {ar_port_q, ar_port_q ? s1_axi.arid : s0_axi.arid};
  assign m_axi.arlen    = ar_port_q ? s1_axi.arlen   : s0_axi.arlen;
  assign m_axi.arsize   = ar_port_q ? s1_axi.arsize  : s0_axi.arsize;
  assign m_axi.arburst  = ar_port_q ? s1_axi.arburst : s0_axi.arburst;
  assign s0_axi.arready = ar_hs & ~ar_port_q;
  assign s1_axi.arready = ar_hs &  ar_port_q;

  assign m_axi.awvalid  = aw_valid;
  assign m_axi.awaddr   = ADDR_W'(aw_port_q ? s1_axi.awaddr : s0_axi.awaddr);
  assign m_axi.awid     = {aw_port_q, aw_port_q ? s1_axi.awid : s0_axi.awid};
  assign m_axi.awlen    = aw_port_q ? s1_axi.awlen   : s0_axi.awlen;
  assign m_axi.awsize   = aw_port_q ? s1_axi.awsize  : s0_axi.awsize;
  assign m_axi.awburst  = aw_port_q ? s1_axi.awburst : s0_axi.awburst;
  assign s0_axi.awready = aw_hs & ~aw_port_q;
  assign s1_axi.awready = aw_hs &  aw_port_q;

  assign m_axi.wvalid   = w_valid;
  assign m_axi.wdata    = DATA_W'(wq_head ? s1_axi.wdata : s0_axi.wdata);
  assign m_axi.wstrb    = STRB_W'(wq_head ? s1_axi.wstrb : s0_axi.wstrb);
  assign m_axi.wlast    = w_last;
  assign s0_axi.wready  = ~wq_empty & ~wq_head & m_axi.wready;
  assign s1_axi.wready  = ~wq_empty &  wq_head & m_axi.wready;

  // Responses return to the port named by the extended ID bit.
  assign s0_axi.rvalid  = m_axi.rvalid & ~m_axi.rid[ID_W];
  assign s1_axi.rvalid  = m_axi.rvalid &  m_axi.rid[ID_W];
  assign s0_axi.rid     = m_axi.rid[ID_W-1:0];
  assign s1_axi.rid     = m_axi.rid[ID_W-1:0];
  assign s0_axi.rdata   = m_axi.rdata;
  assign s1_axi.rdata   = m_axi.rdata;
  assign s0_axi.rresp   = m_axi.rresp;
  assign s1_axi.rresp   = m_axi.rresp;
  assign s0_axi.rlast   = m_axi.rlast;
  assign s1_axi.rlast   = m_axi.rlast;
  assign m_axi.rready   = m_axi.rid[ID_W] ? s1_axi.rready : s0_axi.rready;

  assign s0_axi.bvalid  = m_axi.bvalid & ~m_axi.bid[ID_W];
  assign s1_axi.bvalid  = m_axi.bvalid &  m_axi.bid[ID_W];
  assign s0_axi.bid     = m_axi.bid[ID_W-1:0];
  assign s1_axi.bid     = m_axi.bid[ID_W-1:0];
  assign s0_axi.bresp   = m_axi.bresp;
  assign s1_axi.bresp   = m_axi.bresp;
  assign m_axi.bready   = m_axi.bid[ID_W] ? s1_axi.bready : s0_axi.bready;
endmodule

// File: tb/tb_sbus_axi_arbiter.sv
// Directed bench for sbus_axi_arbiter: the bench plays both requesters and the core.
module tb_sbus_axi_arbiter;
  logic uncoreclk = 1'b0;
  logic uncore_rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  sbus_axi_arbiter_if #(.ADDR_W(32), .DATA_W(64), .ID_W(12)) s0_if ();
  sbus_axi_arbiter_if #(.ADDR_W(32), .DATA_W(64), .ID_W(12)) s1_if ();
  sbus_axi_arbiter_if #(.ADDR_W(32), .DATA_W(64), .ID_W(13)) m_if ();

  sbus_axi_arbiter #(.ADDR_W(32), .DATA_W(64), .ID_W(12), .WQ_DEPTH(4)) dut (
    .uncoreclk (uncoreclk),
    .uncore_rst(uncore_rst),
    .s0_axi    (s0_if.slave),
    .s1_axi    (s1_if.slave),
    .m_axi     (m_if.master)
  );

  always #5 uncoreclk = ~uncoreclk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge uncoreclk);
    #1;
  endtask

  task automatic do_reset();
    uncore_rst = 1'b1;
    step();
    step();
    uncore_rst = 1'b0;
  endtask

  task automatic init_bus();
    s0_if.awvalid = 0; s0_if.awaddr = '0; s0_if.awid = '0; s0_if.awlen = '0;
    s0_if.awsize = 3'd3; s0_if.awburst = 2'd1;
    s0_if.wvalid = 0; s0_if.wdata = '0; s0_if.wstrb = '1; s0_if.wlast = 0; s0_if.bready = 1;
    s0_if.arvalid = 0; s0_if.araddr = '0; s0_if.arid = '0; s0_if.arlen = '0;
    s0_if.arsize = 3'd3; s0_if.arburst = 2'd1; s0_if.rready = 1;
    s1_if.awvalid = 0; s1_if.awaddr = '0; s1_if.awid = '0; s1_if.awlen = '0;
    s1_if.awsize = 3'd3; s1_if.awburst = 2'd1;
    s1_if.wvalid = 0; s1_if.wdata = '0; s1_if.wstrb = '1; s1_if.wlast = 0; s1_if.bready = 1;
    s1_if.arvalid = 0; s1_if.araddr = '0; s1_if.arid = '0; s1_if.arlen = '0;
    s1_if.arsize = 3'd3; s1_if.arburst = 2'd1; s1_if.rready = 1;
    m_if.awready = 0; m_if.wready = 0; m_if.arready = 0;
    m_if.bvalid = 0; m_if.bid = '0; m_if.bresp = '0;
    m_if.rvalid = 0; m_if.rid = '0; m_if.rdata = '0; m_if.rresp = '0; m_if.rlast = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int k, n0, n1, acc, pops;
    logic got_p;
    logic [12:0] exp_id;

    uncore_rst = 1'b1;
    init_bus();
    do_reset();

    // Reset state
    check("rst_valids", {m_if.arvalid, m_if.awvalid, m_if.wvalid}, 3'b000);
    check("rst_readys", {s0_if.arready, s0_if.awready, s0_if.wready,
                         s1_if.arready, s1_if.awready, s1_if.wready}, 6'b0);

    // Single read on s0, ARID 0x005, len 3
    s0_if.arvalid = 1; s0_if.araddr = 32'h0000_1000; s0_if.arid = 12'h005; s0_if.arlen = 8'd3;
    m_if.arready = 1;
    step();
    check("ar_single_valid", m_if.arvalid, 1'b1);
    check("ar_single_id", m_if.arid, 13'h0005);
    check("ar_single_fields", {m_if.araddr, m_if.arlen}, {32'h0000_1000, 8'd3});
    check("ar_single_ready", {s0_if.arready, s1_if.arready}, 2'b10);
    step();
    s0_if.arvalid = 0;
    #1;
    check("ar_single_done", m_if.arvalid, 1'b0);
    m_if.rvalid = 1; m_if.rid = 13'h0005;
    for (int i = 0; i < 4; i++) begin
      m_if.rdata = 64'(100 + i);
      m_if.rlast = (i == 3);
      #1;
      check("r_single_route", {s0_if.rvalid, s1_if.rvalid, s0_if.rid}, {1'b1, 1'b0, 12'h005});
      check("r_single_data", {s0_if.rdata[7:0], s0_if.rlast}, {8'(100 + i), i == 3});
      step();
    end
    m_if.rvalid = 0; m_if.rlast = 0;

    // Both ports request 4 ARs each: strict 0,1 alternation
    do_reset();
    n0 = 0; n1 = 0; k = 0;
    s0_if.arvalid = 1; s0_if.arid = 12'h100;
    s1_if.arvalid = 1; s1_if.arid = 12'h200;
    for (int c = 0; c < 40 && k < 8; c++) begin
      step();
      if (m_if.arvalid) begin
        exp_id = k[0] ? {1'b1, 12'(12'h200 + n1)} : {1'b0, 12'(12'h100 + n0)};
        check("ar_rr_id", m_if.arid, exp_id);
        check("ar_rr_ready", {s0_if.arready, s1_if.arready}, k[0] ? 2'b01 : 2'b10);
        got_p = m_if.arid[12];
        step();
        if (got_p) begin
          n1++; s1_if.arid = 12'(12'h200 + n1);
          if (n1 == 4) s1_if.arvalid = 0;
        end else begin
          n0++; s0_if.arid = 12'(12'h100 + n0);
          if (n0 == 4) s0_if.arvalid = 0;
        end
        k++;
      end
    end
    s0_if.arvalid = 0; s1_if.arvalid = 0; m_if.arready = 0;
    check("ar_rr_count", 64'(k), 64'd8);

    // s1 write len 0, then s0 write len 7 with W ahead of AW
    do_reset();
    m_if.awready = 1; m_if.wready = 1;
    s1_if.awvalid = 1; s1_if.awid = 12'h007; s1_if.awlen = 8'd0;
    s0_if.wvalid = 1; s0_if.wdata = 64'hA0; s0_if.wlast = 0;
    #1;
    check("w_early_hold", {s0_if.wready, m_if.wvalid}, 2'b00);
    step();
    check("aw_s1_id", {m_if.awvalid, m_if.awid}, {1'b1, 13'h1007});
    step();
    s1_if.awvalid = 0;
    s0_if.awvalid = 1; s0_if.awid = 12'h003; s0_if.awlen = 8'd7;
    s1_if.wvalid = 1; s1_if.wdata = 64'hB0; s1_if.wlast = 1;
    #1;
    check("w_s1_beat", {m_if.wvalid, s1_if.wready, s0_if.wready, m_if.wdata[7:0]},
          {1'b1, 1'b1, 1'b0, 8'hB0});
    step();
    s1_if.wvalid = 0;
    #1;
    check("w_s0_still_held", s0_if.wready, 1'b0);
    check("aw_s0_id", {m_if.awvalid, m_if.awid}, {1'b1, 13'h0003});
    step();
    s0_if.awvalid = 0;
    for (int i = 0; i < 8; i++) begin
      s0_if.wdata = 64'(8'hA0 + i);
      s0_if.wlast = (i == 7);
      #1;
      check("w_s0_beat", {m_if.wvalid, s0_if.wready, m_if.wdata[7:0], m_if.wlast},
            {1'b1, 1'b1, 8'(8'hA0 + i), i == 7});
      step();
    end
    s0_if.wvalid = 0; s0_if.wlast = 0;
    #1;
    check("w_fifo_drained", m_if.wvalid, 1'b0);
    m_if.bvalid = 1; m_if.bid = 13'h1007;
    #1;
    check("b_to_s1", {s1_if.bvalid, s0_if.bvalid, s1_if.bid}, {1'b1, 1'b0, 12'h007});
    step();
    m_if.bid = 13'h0003;
    #1;
    check("b_to_s0", {s0_if.bvalid, s1_if.bvalid, s0_if.bid}, {1'b1, 1'b0, 12'h003});
    step();
    m_if.bvalid = 0;

    // W FIFO full with m_wready low: 4 AWs in, 5th waits for a WLAST pop
    do_reset();
    m_if.awready = 1; m_if.wready = 0;
    s0_if.awvalid = 1; s0_if.awid = 12'h040; s0_if.awlen = 8'd0;
    acc = 0;
    for (int c = 0; c < 12; c++) begin
      step();
      if (m_if.awvalid && m_if.awready) acc++;
    end
    check("aw_full_accepts", 64'(acc), 64'd4);
    check("aw_full_blocked", {m_if.awvalid, s0_if.awready, s1_if.awready}, 3'b000);
    s0_if.wvalid = 1; s0_if.wlast = 1; s0_if.wdata = 64'h55;
    m_if.wready = 1;
    #1;
    check("aw_push_pop", {m_if.awvalid, s0_if.awready, m_if.wvalid}, 3'b111);
    step();
    s0_if.awvalid = 0; m_if.wready = 0;
    #1;
    pops = 0;
    m_if.wready = 1;
    #1;
    for (int c = 0; c < 20; c++) begin
      if (!m_if.wvalid) break;
      pops++;
      step();
    end
    check("aw_full_count", 64'(pops), 64'd4);
    s0_if.wvalid = 0; s0_if.wlast = 0;

    // Interleaved R return with s0 backpressure
    s0_if.rready = 0; s1_if.rready = 1;
    m_if.rvalid = 1; m_if.rid = 13'h1011;
    #1;
    check("r_il_s1", {s1_if.rvalid, s0_if.rvalid, m_if.rready}, 3'b101);
    m_if.rid = 13'h0022;
    #1;
    check("r_il_s0_stall", {s0_if.rvalid, s1_if.rvalid, m_if.rready}, 3'b100);
    s0_if.rready = 1;
    #1;
    check("r_il_s0_go", m_if.rready, 1'b1);
    s0_if.rready = 0; m_if.rid = 13'h1033;
    #1;
    check("r_il_s1_unstalled", {s1_if.rvalid, s0_if.rvalid, m_if.rready, s1_if.rid},
          {1'b1, 1'b0, 1'b1, 12'h033});
    m_if.rvalid = 0; s0_if.rready = 1;

    // Reset during an s0 8-beat write at beat 3
    do_reset();
    m_if.awready = 1; m_if.wready = 1;
    s0_if.awvalid = 1; s0_if.awid = 12'h009; s0_if.awlen = 8'd7;
    step();
    step();
    s0_if.awvalid = 0;
    s0_if.wvalid = 1; s0_if.wlast = 0;
    for (int i = 0; i < 3; i++) begin
      s0_if.wdata = 64'(i);
      step();
    end
    s0_if.wdata = 64'd3;
    uncore_rst = 1;
    step();
    uncore_rst = 0;
    check("rst_mid_outputs", {m_if.awvalid, m_if.wvalid, m_if.arvalid, s0_if.wready,
                              s0_if.awready, s0_if.arready, s1_if.wready}, 7'b0);
    s0_if.wvalid = 0;
    s1_if.awvalid = 1; s1_if.awid = 12'h055; s1_if.awlen = 8'd0;
    step();
    check("rst_fresh_aw", {m_if.awvalid, m_if.awid}, {1'b1, 13'h1055});
    step();
    s1_if.awvalid = 0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
